// File: rtl/dut.sv
// 802.11a bit path: x^7+x^4+1 additive scrambler to Antenna, descrambler loopback to Output.
// Scrambling is built only when DUT_SCRAMBLE_EN is defined; otherwise Antenna carries Input unchanged.
module dut #(
    parameter logic [6:0] SEED      = 7'b1111111,
    parameter int         FRAME_LEN = 127
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Input,
    output logic Antenna,
    output logic Output
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(FRAME_LEN - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        tx_valid_reg;
    logic        f_tx;
    logic        f_rx;
    logic        frame_load;

    assign frame_load = (state_reg == IDLE) && Start;

`ifdef DUT_SCRAMBLE_EN
    // An all-zero seed would lock the LFSR, so it falls back to all ones.
    localparam logic [6:0] SEED_INIT = (SEED == 7'd0) ? 7'b1111111 : SEED;

    logic [6:0] lfsr_tx_reg;
    logic [6:0] lfsr_rx_reg;

    assign f_tx = lfsr_tx_reg[6] ^ lfsr_tx_reg[3];
    assign f_rx = lfsr_rx_reg[6] ^ lfsr_rx_reg[3];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr_tx_reg <= SEED_INIT;
            lfsr_rx_reg <= SEED_INIT;
        end else begin
            if (frame_load)
                lfsr_tx_reg <= SEED_INIT;
            else if (state_reg == ACTIVE)
                lfsr_tx_reg <= {lfsr_tx_reg[5:0], f_tx};

            // Reload wins over the final advance of a just-finished frame.
            if (frame_load)
                lfsr_rx_reg <= SEED_INIT;
            else if (tx_valid_reg)
                lfsr_rx_reg <= {lfsr_rx_reg[5:0], f_rx};
        end
    end
`else
    assign f_tx = 1'b0;
    assign f_rx = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            tx_valid_reg <= 1'b0;
            Antenna      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    Antenna      <= 1'b0;
                    tx_valid_reg <= 1'b0;
                    if (Start) begin
                        state_reg <= ACTIVE;
                        count_reg <= '0;
                    end
                end
                ACTIVE: begin
                    Antenna      <= Input ^ f_tx;
                    tx_valid_reg <= 1'b1;
                    count_reg    <= count_reg + 16'd1;
                    if (count_reg == LAST_COUNT)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            Output <= 1'b0;
        else if (tx_valid_reg)
            Output <= Antenna ^ f_rx;
        else
            Output <= 1'b0;
    end

endmodule

// File: tb/tb_dut.sv
// Randomized self-checking bench for dut; a second instance uses SEED=0 and must match the default seed.
`timescale 1ns/1ps
module tb_dut;

    localparam int FLEN = 127;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b0;
    logic Input = 1'b0;
    logic ant_a, out_a, ant_b, out_b;

    int n_checks = 0;
    int n_errors = 0;

    bit ks [FLEN];
    bit bits [FLEN];

    dut #(.SEED(7'b1111111), .FRAME_LEN(FLEN)) u_dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Input(Input),
        .Antenna(ant_a), .Output(out_a)
    );

    dut #(.SEED(7'b0000000), .FRAME_LEN(FLEN)) u_dut_zero (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Input(Input),
        .Antenna(ant_b), .Output(out_b)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic exp_ant, input logic exp_out);
        check({tag, " ant"}, ant_a, exp_ant);
        check({tag, " out"}, out_a, exp_out);
        check({tag, " ant_seed0"}, ant_b, exp_ant);
        check({tag, " out_seed0"}, out_b, exp_out);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // mode 0: all zero data, 1: random data; mid/end select a stray Start pulse.
    task automatic run_frame(input string name, input int mode, input bit mid, input bit at_end);
        int diff = 0;
        for (int i = 0; i < FLEN; i++) bits[i] = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        Start = 1'b1;
        Input = 1'($urandom_range(0, 1));
        tick();
        check_both({name, " start"}, 1'b0, 1'b0);
        Start = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            Input = bits[i];
            Start = (mid && i == 50) || (at_end && i == FLEN - 1);
            tick();
            check_both($sformatf("%s bit%0d", name, i), bits[i] ^ ks[i],
                       (i == 0) ? 1'b0 : bits[i-1]);
            if (ant_a != bits[i]) diff++;
        end
        Start = 1'b0;
        Input = 1'b1;
        tick();
        check_both({name, " tail1"}, 1'b0, bits[FLEN-1]);
        tick();
        check_both({name, " tail2"}, 1'b0, 1'b0);
        tick();
        check_both({name, " tail3"}, 1'b0, 1'b0);
        if (mode == 1) begin
`ifdef DUT_SCRAMBLE_EN
            check({name, " scrambled"}, diff > 0, 1'b1);
`else
            check({name, " passthrough"}, diff == 0, 1'b1);
`endif
        end
        $display("frame %s done, %0d antenna bits differ from input", name, diff);
    endtask

    initial begin
        bit [6:0] s;
        bit [15:0] head;
        s = 7'b1111111;
        // Keystream of x^7+x^4+1 from the all-ones seed, one bit per frame position.
        for (int i = 0; i < FLEN; i++) begin
`ifdef DUT_SCRAMBLE_EN
            ks[i] = s[6] ^ s[3];
`else
            ks[i] = 1'b0;
`endif
            s = {s[5:0], s[6] ^ s[3]};
        end

        #2;
        check_both("reset", 1'b0, 1'b0);
        #20;
        Reset = 1'b1;

        for (int i = 0; i < FLEN; i++) begin
            Input = 1'($urandom_range(0, 1));
            tick();
            check_both($sformatf("idle%0d", i), 1'b0, 1'b0);
        end

        run_frame("zeros", 0, 1'b0, 1'b0);

`ifdef DUT_SCRAMBLE_EN
        head = 16'b0000111011110010;
        Start = 1'b1;
        Input = 1'b0;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("pn_head%0d", i), ant_a, head[15-i]);
        end
        for (int i = 16; i < FLEN + 3; i++) tick();
`endif

        run_frame("random", 1, 1'b0, 1'b0);
        run_frame("mid_start", 1, 1'b1, 1'b0);
        run_frame("end_start", 1, 1'b0, 1'b1);

        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            Input = 1'($urandom_range(0, 1));
            tick();
        end
        #2;
        Reset = 1'b0;
        #1;
        check_both("async_reset", 1'b0, 1'b0);
        tick();
        check_both("in_reset", 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        check_both("post_reset", 1'b0, 1'b0);

        run_frame("after_reset", 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dut.md
Name: dut

Overview:
- Top-level integration block for the 802.11a bit path: additive scrambler on the transmit side drives `Antenna`; a matching descrambler loops `Antenna` back to `Output`.
- In steady state `Output` equals `Input` delayed by one cycle within a frame.
- `Output` is 0 whenever no frame is active, including after reset.

Parameters:
- SEED, 7'b1111111, initial scrambler/descrambler state loaded at frame start; value 0 is illegal and is replaced by 7'b1111111.
- FRAME_LEN, 127, number of `Input` bits accepted per frame (1..65535).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  frame start request; sampled on the rising edge.
- Input  input  1  serial data bit; sampled during the ACTIVE state.
- Antenna  output  1  registered scrambled transmit bit.
- Output  output  1  registered descrambled loopback bit.

Behaviour:
- Reset (Reset=0, async), all of the following:
  - state=IDLE, bit counter=0, tx_valid=0
  - lfsr_tx=lfsr_rx=SEED
  - Antenna=0, Output=0
  - Reset mid-frame aborts the frame immediately.
- Scrambler polynomial x^7+x^4+1, state s[6:0]:
  - feedback f = s[6]^s[3]
  - next state s <= {s[5:0], f}
  - sequence period 127
- States IDLE and ACTIVE.
- IDLE:
  - Antenna <= 0, tx_valid <= 0.
  - On a rising edge with Start=1: state <= ACTIVE, counter <= 0, lfsr_tx <= SEED, lfsr_rx <= SEED.
- ACTIVE, each edge:
  - Antenna <= Input ^ f_tx; lfsr_tx advances; tx_valid <= 1; counter++.
  - When counter reaches FRAME_LEN-1 on this edge, state <= IDLE (exactly FRAME_LEN bits accepted).
- Start while ACTIVE is ignored (no restart).
- Start on the same edge that ends a frame is ignored; a new frame needs Start asserted in IDLE.
- Descrambler, each edge:
  - If tx_valid=1: Output <= Antenna ^ f_rx and lfsr_rx advances.
  - Else Output <= 0 and lfsr_rx holds.
- Latency:
  - `Input` sampled at edge k appears scrambled on `Antenna` after edge k.
  - The same bit appears unscrambled on `Output` after edge k+1.
- First `Antenna` bit of a frame is produced at the edge after the one that sampled Start.
- Back-to-back frames: IDLE lasts at least one cycle between frames.
- With Start never asserted: Antenna=0 and Output=0 forever, regardless of `Input`.

Optional Feature:
- Macro DUT_SCRAMBLE_EN.
- Defined: scrambling/descrambling as above.
- Undefined:
  - f_tx and f_rx are forced to 0, so Antenna = Input (registered) during ACTIVE.
  - Both LFSR registers are removed; the remaining timing and state machine are unchanged.
  - Output still equals Input delayed one cycle.

Test Plan:
- Reset pulse, Start=0, Input=0, run 127 cycles -> Output=0 and Antenna=0 every cycle.
- Start=1 for one edge, SEED=7'b1111111, Input=0 for 127 bits -> Antenna sequence begins 0,0,0,0,1,1,1,0,1,1,1,1,0,0,1,0 and repeats with period 127; Output=0 throughout.
- Start, then random Input for FRAME_LEN bits -> Output(edge k+1) == Input(edge k) for all bits.
  - Antenna != Input on at least one bit.
  - After FRAME_LEN bits, Antenna=0 and Output=0.
- Start pulsed again mid-frame -> ignored: bit count and Antenna sequence continue unchanged; frame ends after FRAME_LEN bits.
- Reset asserted mid-frame -> Antenna=0 and Output=0 immediately (asynchronously).
  - After release, the next Start reproduces the same SEED sequence from its first bit.
- SEED=0 override -> behaves identically to SEED=7'b1111111.
